cursor_pos_counter: RTL and testbench
=====================================

// Module: cursor_pos_counter
// PURPOSE
//  Parametrised cursor/digit-position counter for the calculator input unit.
//  - Synchronises the asynchronous keypad strobe and detects its rising edge.
//  - Moves a position index up or down, or back to home, according to the key code.
//  - Adds saturate/wrap mode, key-hold auto-repeat, a synchronous clear and status flags.
//  - Drives the digit-entry datapath and the display cursor.
// PARAMETERS
//  POS_W       3        width of count; MAX_POS < 2**POS_W (elaboration check)
//  MAX_POS     5        highest legal position; range is 0..MAX_POS
//  KEY_W       4        width of key code bus
//  KEY_INC     4'b1111  key code: move right (+1)
//  KEY_DEC     4'b1101  key code: move left (-1)
//  KEY_HOME    4'b1110  key code: jump to position 0
//  WRAP        0        0 = saturate at the ends; 1 = wrap around
//  SYNC_STAGES 2        synchroniser depth on pre (>=2)
//  HOLD_CYC    16       cycles from the first step to the first auto-repeat step (>=2)
//  REPEAT_CYC  4        cycles between later auto-repeat steps (>=2)
// PORTS
//  clk     in  1      system clock
//  reset   in  1      asynchronous, active-low reset
//  pre     in  1      async key-pressed strobe; high while a key is held
//  value   in  KEY_W  key code; stable whenever pre is high
//  clear   in  1      synchronous: force count to 0
//  count   out POS_W  current position
//  at_min  out 1      count == 0 (combinational from count)
//  at_max  out 1      count == MAX_POS (combinational from count)
//  moved   out 1      1-cycle pulse: count changed on this edge
// BEHAVIOUR
//  Reset (async, low): count=0, moved=0, sync chain=0, history flop=0, FSM=IDLE, timer=0.
//  Synchroniser and edge detect
//   - pre passes through SYNC_STAGES flops to give ps; a history flop holds the previous ps.
//   - press = ps & ~ps_prev.
//   - pre first sampled high at edge E0 -> count updates at edge E0+SYNC_STAGES.
//  Step function f(key)
//   - INC: count==MAX_POS ? (WRAP ? 0 : MAX_POS) : count+1
//   - DEC: count==0 ? (WRAP ? MAX_POS : 0) : count-1
//   - HOME: 0. Any other code: no change.
//  FSM: IDLE, HOLD, REPEAT, LOCK. The key is latched into key_q on press.
//   - IDLE: on press, apply f(value) and clear timer.
//     - INC/DEC keys -> HOLD. All other keys -> LOCK.
//   - HOLD: timer increments.
//     - !ps -> IDLE.
//     - timer==HOLD_CYC-1 -> apply f(key_q), clear timer, go to REPEAT.
//   - REPEAT: timer increments.
//     - !ps -> IDLE.
//     - timer==REPEAT_CYC-1 -> apply f(key_q), clear timer.
//   - LOCK: stay until !ps, then -> IDLE. No repeats.
//  Step timing
//   - Initial step at edge T0; first repeat at T0+HOLD_CYC; then every REPEAT_CYC.
//   - A change in value while the key is held is ignored; key_q is used.
//   - A release and re-press needs ps low for at least 1 cycle; the FSM returns to IDLE
//     first, so a new press is accepted only after that.
//  Priority per edge: reset > clear > step.
//   - clear: count<=0, FSM<=IDLE, timer<=0.
//     - A held key does not repeat after clear; a fresh edge is required.
//   - clear and press in the same cycle: clear wins and the press is dropped.
//  moved is registered and high for exactly the edge where the new count differs from the
//  old. A saturated step, HOME at 0, or clear at 0 gives moved=0.
//  timer width is $clog2(max(HOLD_CYC,REPEAT_CYC)). No arithmetic overflow is possible;
//  count never leaves 0..MAX_POS.
// TESTING (bench: HOLD_CYC=16, REPEAT_CYC=4, SYNC_STAGES=2)
//  1. Reset low mid-press with count=3 -> count=0, moved=0, FSM IDLE at once; no step after
//     release of reset until a new edge.
//  2. WRAP=0: 7 single INC taps from 0 -> count 1,2,3,4,5,5,5; moved pulses 5 times;
//     at_max=1 after tap 5; DEC at 0 -> stays 0.
//  3. WRAP=1: count=5, INC tap -> 0 with moved=1; DEC tap -> 5.
//  4. Hold INC for 30 cycles from 0
//     - Steps at T0, T0+16, T0+20, T0+24, T0+28 -> count=5.
//     - Release -> no further change.
//  5. Key tap timing: pre rises before edge E0 -> count changes at E0+2, not E0+1.
//  6. HOME held at count=4 -> 0 once (LOCK, no repeat).
//  7. clear asserted with INC held in REPEAT
//     - count=0, no later repeats while held.
//     - clear coincident with press -> count=0, press ignored.

Source files
------------

// File: rtl/cursor_pos_counter.sv
// Cursor/digit-position counter for the calculator input unit: synchronised key strobe,
// saturating or wrapping step, key-hold auto-repeat, synchronous clear and position flags.
module cursor_pos_counter #(
    parameter int unsigned      POS_W       = 3,
    parameter int unsigned      MAX_POS     = 5,
    parameter int unsigned      KEY_W       = 4,
    parameter logic [KEY_W-1:0] KEY_INC     = 4'b1111,
    parameter logic [KEY_W-1:0] KEY_DEC     = 4'b1101,
    parameter logic [KEY_W-1:0] KEY_HOME    = 4'b1110,
    parameter bit               WRAP        = 1'b0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      HOLD_CYC    = 16,
    parameter int unsigned      REPEAT_CYC  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pre,
    input  logic [KEY_W-1:0] value,
    input  logic             clear,
    output logic [POS_W-1:0] count,
    output logic             at_min,
    output logic             at_max,
    output logic             moved
);

    localparam int unsigned TIMER_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [POS_W-1:0]   MAX_Q       = POS_W'(MAX_POS);
    localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYC - 1);
    localparam logic [TIMER_W-1:0] REPEAT_LAST = TIMER_W'(REPEAT_CYC - 1);

    if (MAX_POS >= (2 ** POS_W)) begin : g_chk_pos
        $error("cursor_pos_counter: MAX_POS does not fit in POS_W bits");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("cursor_pos_counter: SYNC_STAGES must be at least 2");
    end
    if (HOLD_CYC < 2 || REPEAT_CYC < 2) begin : g_chk_timer
        $error("cursor_pos_counter: HOLD_CYC and REPEAT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ps_prev;
    logic [TIMER_W-1:0]     timer, timer_n;
    logic [KEY_W-1:0]       key_q, key_n;
    logic [POS_W-1:0]       count_n;
    logic                   moved_n;
    logic                   ps;
    logic                   press;

    assign ps     = sync_q[SYNC_STAGES-1];
    assign press  = ps & ~ps_prev;
    assign at_min = (count == '0);
    assign at_max = (count == MAX_Q);

    // One step of the position for a given key; unknown codes leave the position alone.
    function automatic logic [POS_W-1:0] step_fn(input logic [KEY_W-1:0] key,
                                                 input logic [POS_W-1:0] cur);
        logic [POS_W-1:0] nxt;
        nxt = cur;
        if (key == KEY_INC) begin
            nxt = (cur == MAX_Q) ? (WRAP ? '0 : MAX_Q) : cur + POS_W'(1);
        end else if (key == KEY_DEC) begin
            nxt = (cur == '0) ? (WRAP ? MAX_Q : '0) : cur - POS_W'(1);
        end else if (key == KEY_HOME) begin
            nxt = '0;
        end
        return nxt;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= '0;
            ps_prev <= 1'b0;
            state   <= IDLE;
            timer   <= '0;
            key_q   <= '0;
            count   <= '0;
            moved   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pre};
            ps_prev <= ps;
            state   <= state_n;
            timer   <= timer_n;
            key_q   <= key_n;
            count   <= count_n;
            moved   <= moved_n;
        end
    end

    // Next-state: clear overrides everything, otherwise the key FSM decides the step.
    always_comb begin
        state_n = state;
        timer_n = timer;
        key_n   = key_q;
        count_n = count;

        if (clear) begin
            count_n = '0;
            state_n = IDLE;
            timer_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (press) begin
                        count_n = step_fn(value, count);
                        key_n   = value;
                        timer_n = '0;
                        state_n = (value == KEY_INC || value == KEY_DEC) ? HOLD : LOCK;
                    end
                end
                HOLD: begin
                    if (!ps) begin
                        state_n = IDLE;
                    end else if (timer == HOLD_LAST) begin
                        count_n = step_fn(key_q, count);
                        timer_n = '0;
                        state_n = REPEAT;
                    end else begin
                        timer_n = timer + TIMER_W'(1);
                    end
                end
                REPEAT: begin
                    if (!ps) begin
                        state_n = IDLE;
                    end else if (timer == REPEAT_LAST) begin
                        count_n = step_fn(key_q, count);
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TIMER_W'(1);
                    end
                end
                LOCK: begin
                    if (!ps) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        moved_n = (count_n != count);
    end

endmodule

// File: tb/tb_cursor_pos_counter.sv
// Bench for cursor_pos_counter: a saturating and a wrapping instance, expectations scheduled
// per clock cycle in a scoreboard queue and compared on the falling edge.
module tb_cursor_pos_counter;

    localparam int unsigned MAX_POS = 5;
    localparam logic [3:0]  K_INC   = 4'b1111;
    localparam logic [3:0]  K_DEC   = 4'b1101;
    localparam logic [3:0]  K_HOME  = 4'b1110;
    localparam logic [3:0]  K_OTH   = 4'b0011;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       pre,  pre_w;
    logic [3:0] value, value_w;
    logic [2:0] count, count_w;
    logic       at_min, at_max, moved;
    logic       at_min_w, at_max_w, moved_w;

    cursor_pos_counter #(.WRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .pre(pre), .value(value), .clear(clear),
        .count(count), .at_min(at_min), .at_max(at_max), .moved(moved)
    );

    cursor_pos_counter #(.WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .pre(pre_w), .value(value_w), .clear(clear),
        .count(count_w), .at_min(at_min_w), .at_max(at_max_w), .moved(moved_w)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         inst;
        logic [2:0] cnt;
        logic       mv;
        string      tag;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        logic [2:0] cnt;
        logic       mv;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5:0] pack(input logic [2:0] c, input logic m);
        return {c, m, c == 3'd0, c == 3'(MAX_POS)};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got cnt/mv/min/max=%b want=%b", tag, cyc, got, want);
        end
    endtask

    task automatic push(input int at, input bit inst, input logic [2:0] c, input logic m,
                        input string tag);
        exp_t e;
        e.at = at; e.inst = inst; e.cnt = c; e.mv = m; e.tag = tag;
        sb.push_back(e);
    endtask

    // Compare every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(sb[i].tag,
                      sb[i].inst ? {count_w, moved_w, at_min_w, at_max_w}
                                 : {count, moved, at_min, at_max},
                      pack(sb[i].cnt, sb[i].mv));
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never compared", sb[i].tag, sb[i].at);
                sb.delete(i);
            end
        end
    end

    task automatic drive(input bit inst, input logic p, input logic [3:0] k);
        if (inst) begin
            pre_w = p; value_w = k;
        end else begin
            pre = p; value = k;
        end
    endtask

    // Short key tap: no change 2 cycles after pre rises, step after 3, single-cycle moved.
    task automatic tap(input bit inst, input logic [3:0] k, input logic [2:0] old,
                       input logic [2:0] nw, input logic mv, input string tag);
        int c;
        c = cyc;
        push(c + 2, inst, old, 1'b0, {tag, "_early"});
        push(c + 3, inst, nw,  mv,   tag);
        push(c + 4, inst, nw,  1'b0, {tag, "_after"});
        drive(inst, 1'b1, k);
        repeat (2) @(negedge clk);
        drive(inst, 1'b0, k);
        repeat (4) @(negedge clk);
    endtask

    vec_t       vecs[12];
    logic [2:0] prev;
    int         c;

    initial begin
        vecs[0]  = '{K_INC,  3'd1, 1'b1};
        vecs[1]  = '{K_INC,  3'd2, 1'b1};
        vecs[2]  = '{K_INC,  3'd3, 1'b1};
        vecs[3]  = '{K_INC,  3'd4, 1'b1};
        vecs[4]  = '{K_INC,  3'd5, 1'b1};
        vecs[5]  = '{K_INC,  3'd5, 1'b0};
        vecs[6]  = '{K_INC,  3'd5, 1'b0};
        vecs[7]  = '{K_HOME, 3'd0, 1'b1};
        vecs[8]  = '{K_DEC,  3'd0, 1'b0};
        vecs[9]  = '{K_OTH,  3'd0, 1'b0};
        vecs[10] = '{K_INC,  3'd1, 1'b1};
        vecs[11] = '{K_DEC,  3'd0, 1'b1};

        reset = 1'b0; clear = 1'b0;
        pre = 1'b0; value = '0; pre_w = 1'b0; value_w = '0;
        repeat (3) @(negedge clk);
        check("reset_state",   {count, moved, at_min, at_max},         pack(3'd0, 1'b0));
        check("reset_state_w", {count_w, moved_w, at_min_w, at_max_w}, pack(3'd0, 1'b0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Saturating taps, including the ends and an unknown key code.
        prev = 3'd0;
        for (int i = 0; i < 12; i++) begin
            tap(1'b0, vecs[i].key, prev, vecs[i].cnt, vecs[i].mv, $sformatf("tap%0d", i));
            prev = vecs[i].cnt;
        end

        // Wrapping instance: climb to the top, then wrap both ways.
        for (int i = 0; i < 5; i++) begin
            tap(1'b1, K_INC, 3'(i), 3'(i + 1), 1'b1, $sformatf("wtap%0d", i));
        end
        tap(1'b1, K_INC, 3'd5, 3'd0, 1'b1, "wrap_up");
        tap(1'b1, K_DEC, 3'd0, 3'd5, 1'b1, "wrap_down");

        // Held INC: first step, repeat after 16 cycles, then every 4; value change ignored.
        c = cyc;
        push(c + 3,  0, 3'd1, 1'b1, "hold_t0");
        push(c + 4,  0, 3'd1, 1'b0, "hold_t0_after");
        push(c + 18, 0, 3'd1, 1'b0, "hold_pre16");
        push(c + 19, 0, 3'd2, 1'b1, "hold_t16");
        push(c + 22, 0, 3'd2, 1'b0, "hold_pre20");
        push(c + 23, 0, 3'd3, 1'b1, "hold_t20");
        push(c + 26, 0, 3'd3, 1'b0, "hold_pre24");
        push(c + 27, 0, 3'd4, 1'b1, "hold_t24");
        push(c + 30, 0, 3'd4, 1'b0, "hold_pre28");
        push(c + 31, 0, 3'd5, 1'b1, "hold_t28");
        push(c + 32, 0, 3'd5, 1'b0, "hold_t28_after");
        push(c + 40, 0, 3'd5, 1'b0, "hold_released");
        drive(1'b0, 1'b1, K_INC);
        repeat (10) @(negedge clk);
        value = K_DEC;
        repeat (20) @(negedge clk);
        pre = 1'b0;
        repeat (14) @(negedge clk);

        tap(1'b0, K_DEC, 3'd5, 3'd4, 1'b1, "dec_to4");

        // Held HOME: one jump to 0, never repeats even if value changes.
        c = cyc;
        push(c + 3,  0, 3'd0, 1'b1, "home_t0");
        push(c + 4,  0, 3'd0, 1'b0, "home_after");
        push(c + 19, 0, 3'd0, 1'b0, "home_no_rep16");
        push(c + 24, 0, 3'd0, 1'b0, "home_no_rep21");
        push(c + 30, 0, 3'd0, 1'b0, "home_released");
        drive(1'b0, 1'b1, K_HOME);
        repeat (10) @(negedge clk);
        value = K_INC;
        repeat (15) @(negedge clk);
        pre = 1'b0;
        repeat (8) @(negedge clk);

        // clear while INC auto-repeats: back to 0 and no further repeats while held.
        c = cyc;
        push(c + 3,  0, 3'd1, 1'b1, "clr_t0");
        push(c + 19, 0, 3'd2, 1'b1, "clr_t16");
        push(c + 23, 0, 3'd3, 1'b1, "clr_t20");
        push(c + 24, 0, 3'd3, 1'b0, "clr_before");
        push(c + 25, 0, 3'd0, 1'b1, "clr_applied");
        push(c + 26, 0, 3'd0, 1'b0, "clr_after");
        push(c + 27, 0, 3'd0, 1'b0, "clr_no_rep27");
        push(c + 30, 0, 3'd0, 1'b0, "clr_no_rep30");
        push(c + 40, 0, 3'd0, 1'b0, "clr_no_rep40");
        push(c + 45, 0, 3'd0, 1'b0, "clr_no_rep45");
        drive(1'b0, 1'b1, K_INC);
        repeat (24) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        pre = 1'b0;
        repeat (6) @(negedge clk);

        // clear on the same edge as the press: press dropped, nothing later while held.
        c = cyc;
        push(c + 3,  0, 3'd0, 1'b0, "clrpress_edge");
        push(c + 4,  0, 3'd0, 1'b0, "clrpress_after");
        push(c + 19, 0, 3'd0, 1'b0, "clrpress_no_hold");
        push(c + 24, 0, 3'd0, 1'b0, "clrpress_no_rep");
        drive(1'b0, 1'b1, K_INC);
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (22) @(negedge clk);
        pre = 1'b0;
        repeat (6) @(negedge clk);
        tap(1'b0, K_INC, 3'd0, 3'd1, 1'b1, "fresh_after_clear");

        // Reset asserted mid-press with count at 3 takes effect immediately.
        tap(1'b0, K_INC, 3'd1, 3'd2, 1'b1, "pre_rst_a");
        tap(1'b0, K_INC, 3'd2, 3'd3, 1'b1, "pre_rst_b");
        c = cyc;
        push(c + 2, 0, 3'd3, 1'b0, "rst_press_early");
        drive(1'b0, 1'b1, K_INC);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_async",   {count, moved, at_min, at_max},         pack(3'd0, 1'b0));
        check("rst_async_w", {count_w, moved_w, at_min_w, at_max_w}, pack(3'd0, 1'b0));
        @(negedge clk);
        pre = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push(c + 3,  0, 3'd0, 1'b0, "rst_no_step3");
        push(c + 20, 0, 3'd0, 1'b0, "rst_no_step20");
        repeat (21) @(negedge clk);
        tap(1'b0, K_INC, 3'd0, 3'd1, 1'b1, "post_reset");

        for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge clk);
        while (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for cycle %0d still pending", sb[0].tag, sb[0].at);
            void'(sb.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
